// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter sharing one UART TX FIFO write port
// between N_REQ byte-stream requesters, with a per-grant byte limit.

module uart_tx_arb_lane #(
  parameter int DBIT = 8
) (
  input  logic            i_grant,
  input  logic            i_fire,
  input  logic [DBIT-1:0] i_data,
  output logic            o_ready,
  output logic [DBIT-1:0] o_data
);
  // Masked lane data lets the top OR-reduce lanes instead of muxing.
  assign o_ready = i_grant & i_fire;
  assign o_data  = i_grant ? i_data : '0;
endmodule

module uart_tx_arbiter #(
  parameter int N_REQ   = 3,
  parameter int DBIT    = 8,
  parameter int MAX_PKT = 64
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [N_REQ-1:0]      i_req_valid,
  input  logic [N_REQ*DBIT-1:0] i_req_data,
  input  logic [N_REQ-1:0]      i_req_last,
  output logic [N_REQ-1:0]      o_req_ready,
  output logic [N_REQ-1:0]      o_grant,
  output logic                  o_trunc,
  output logic                  o_wr_uart,
  output logic [DBIT-1:0]       o_wr_data,
  input  logic                  i_tx_full
);
  localparam int PW = $clog2(N_REQ);

  typedef enum logic {S_IDLE, S_LOCK} state_t;

  state_t                          r_state, w_state_nxt;
  logic   [N_REQ-1:0]              r_grant, w_grant_nxt;
  logic   [PW-1:0]                 r_ptr,   w_ptr_nxt;
  logic   [7:0]                    r_cnt,   w_cnt_nxt;
  logic                            r_trunc, w_trunc_nxt;

  logic   [N_REQ-1:0][DBIT-1:0]    w_lane_data;
  logic   [N_REQ-1:0][DBIT-1:0]    w_lane_masked;
  logic                            w_g_valid, w_g_last, w_fire;
  logic                            w_any;
  logic   [PW-1:0]                 w_sel;
  logic   [N_REQ-1:0]              w_sel_oh;

  assign w_lane_data = i_req_data;
  assign w_g_valid   = |(i_req_valid & r_grant);
  assign w_g_last    = |(i_req_last  & r_grant);
  // Reset gates the strobe so nothing reaches the FIFO while rst_n is low.
  assign w_fire      = (r_state == S_LOCK) & w_g_valid & ~i_tx_full & i_rst_n;

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_lane
    uart_tx_arb_lane #(.DBIT(DBIT)) u_lane (
      .i_grant (r_grant[gi]),
      .i_fire  (w_fire),
      .i_data  (w_lane_data[gi]),
      .o_ready (o_req_ready[gi]),
      .o_data  (w_lane_masked[gi])
    );
  end

  always_comb begin
    o_wr_data = '0;
    for (int i = 0; i < N_REQ; i++) o_wr_data = o_wr_data | w_lane_masked[i];
  end

  // Round-robin pick: first valid bit scanning upward from r_ptr+1 with wrap.
  always_comb begin : p_sel
    int idx;
    w_any    = 1'b0;
    w_sel    = '0;
    w_sel_oh = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = int'(r_ptr) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!w_any && i_req_valid[idx]) begin
        w_any = 1'b1;
        w_sel = PW'(idx);
      end
    end
    w_sel_oh[w_sel] = 1'b1;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_ptr_nxt   = r_ptr;
    w_cnt_nxt   = r_cnt;
    w_trunc_nxt = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_state_nxt = S_LOCK;
          w_grant_nxt = w_sel_oh;
          w_ptr_nxt   = w_sel;
          w_cnt_nxt   = '0;
        end
      end
      S_LOCK: begin
        if (w_fire) begin
          w_cnt_nxt = r_cnt + 8'd1;
          if (w_g_last) begin
            w_state_nxt = S_IDLE;
            w_grant_nxt = '0;
          end else if (r_cnt + 8'd1 == 8'(MAX_PKT)) begin
            w_state_nxt = S_IDLE;
            w_grant_nxt = '0;
            w_trunc_nxt = 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_grant_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_grant <= '0;
      r_ptr   <= PW'(N_REQ - 1);
      r_cnt   <= '0;
      r_trunc <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      r_ptr   <= w_ptr_nxt;
      r_cnt   <= w_cnt_nxt;
      r_trunc <= w_trunc_nxt;
    end
  end

  assign o_grant   = r_grant;
  assign o_trunc   = r_trunc;
  assign o_wr_uart = w_fire;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter (N_REQ=3, DBIT=8, MAX_PKT=4).
module tb_uart_tx_arbiter;
  localparam int N = 3;
  localparam int DB = 8;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req_valid, req_last, req_ready, grant;
  logic [N*DB-1:0] req_data;
  logic           trunc, wr_uart, tx_full;
  logic [DB-1:0]  wr_data;

  uart_tx_arbiter #(.N_REQ(N), .DBIT(DB), .MAX_PKT(4)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_req_valid(req_valid), .i_req_data(req_data),
    .i_req_last(req_last), .o_req_ready(req_ready), .o_grant(grant), .o_trunc(trunc),
    .o_wr_uart(wr_uart), .o_wr_data(wr_data), .i_tx_full(tx_full)
  );

  always #5 clk = ~clk;

  logic [7:0] bdat [N][16];
  logic       blast[N][16];
  int         bn[N], bi[N];
  logic [7:0] wlog[64];
  logic [2:0] wg[64];
  int         wc[64];
  int         wn, tn, tc, ncyc;
  int         n_tests = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req_valid[i]       = bi[i] < bn[i];
      req_data[i*DB +: DB] = (bi[i] < bn[i]) ? bdat[i][bi[i]] : 8'h00;
      req_last[i]        = (bi[i] < bn[i]) ? blast[i][bi[i]] : 1'b0;
    end
  endtask

  task automatic load(input int r, input logic [7:0] base, input int n);
    for (int k = 0; k < n; k++) begin
      bdat[r][k]  = base + 8'(k);
      blast[r][k] = (k == n - 1);
    end
    bn[r] = n;
    bi[r] = 0;
  endtask

  // One clock: log writes/trunc at negedge, then consume accepted bytes after the edge.
  task automatic tick();
    logic [N-1:0] rdy;
    @(negedge clk);
    if (wr_uart) begin
      wlog[wn] = wr_data; wg[wn] = grant; wc[wn] = ncyc; wn++;
    end
    if (trunc) begin tn++; tc = ncyc; end
    rdy = req_ready;
    @(posedge clk); #1;
    for (int i = 0; i < N; i++) if (rdy[i]) bi[i]++;
    drive();
    ncyc++;
    #1;
  endtask

  task automatic run_until(input int target, input int budget);
    for (int c = 0; c < budget && wn < target; c++) tick();
  endtask

  initial begin
    rst_n = 1'b0; tx_full = 1'b0; wn = 0; tn = 0; tc = -1; ncyc = 0;
    for (int i = 0; i < N; i++) begin bn[i] = 0; bi[i] = 0; end
    drive();
    tick(); tick();

    // Reset with every requester valid; nothing may be granted or written.
    load(0, 8'hA0, 2); load(1, 8'hB0, 2); load(2, 8'hC0, 2); drive();
    for (int r = 0; r < 3; r++) begin
      tick();
      chk("rst_grant", grant, 0);
      chk("rst_wr", wr_uart, 0);
      chk("rst_ready", req_ready, 0);
    end
    rst_n = 1'b1;
    tick();
    chk("rr_first_grant", grant, 3'b001);
    chk("rr_first_data", wr_data, 8'hA0);
    run_until(6, 40);
    chk("rr_count", wn, 6);
    chk("rr_d0", wlog[0], 8'hA0); chk("rr_d1", wlog[1], 8'hA1);
    chk("rr_d2", wlog[2], 8'hB0); chk("rr_d3", wlog[3], 8'hB1);
    chk("rr_d4", wlog[4], 8'hC0); chk("rr_d5", wlog[5], 8'hC1);
    chk("rr_g0", wg[0], 3'b001); chk("rr_g2", wg[2], 3'b010); chk("rr_g4", wg[4], 3'b100);
    chk("rr_b2b", wc[1] - wc[0], 1);
    chk("rr_bubble1", wc[2] - wc[1], 2);
    chk("rr_bubble2", wc[4] - wc[3], 2);
    tick(); tick();

    // Backpressure: 4-byte packet, FIFO full for four cycles after first byte.
    wn = 0; tn = 0;
    load(1, 8'h10, 4); drive();
    tick();
    chk("bp_grant", grant, 3'b010);
    tick();
    chk("bp_first", wn, 1);
    for (int s = 0; s < 4; s++) begin
      tx_full = 1'b1; #1;
      chk("bp_no_wr", wr_uart, 0);
      tick();
      chk("bp_hold_grant", grant, 3'b010);
    end
    chk("bp_stalled_cnt", wn, 1);
    tx_full = 1'b0;
    run_until(4, 20);
    tick(); tick();
    chk("bp_count", wn, 4);
    chk("bp_d0", wlog[0], 8'h10); chk("bp_d1", wlog[1], 8'h11);
    chk("bp_d2", wlog[2], 8'h12); chk("bp_d3", wlog[3], 8'h13);
    chk("bp_last_at_limit_trunc", tn, 0);

    // Forced release after 4 bytes with requester 2 pending.
    wn = 0; tn = 0; tc = -1;
    load(0, 8'h50, 6); drive();
    tick();
    chk("fr_grant0", grant, 3'b001);
    load(2, 8'h70, 2); drive();
    run_until(8, 40);
    tick(); tick();
    chk("fr_count", wn, 8);
    chk("fr_d3", wlog[3], 8'h53);
    chk("fr_trunc_cnt", tn, 1);
    chk("fr_trunc_when", tc, wc[3] + 1);
    chk("fr_d4", wlog[4], 8'h70); chk("fr_g4", wg[4], 3'b100);
    chk("fr_d5", wlog[5], 8'h71);
    chk("fr_d6", wlog[6], 8'h54); chk("fr_g6", wg[6], 3'b001);
    chk("fr_d7", wlog[7], 8'h55);

    // Last byte coincides with the limit: normal release.
    wn = 0; tn = 0;
    load(0, 8'h60, 4); drive();
    run_until(4, 20);
    tick(); tick();
    chk("lal_count", wn, 4);
    chk("lal_trunc", tn, 0);
    chk("lal_idle", grant, 0);

    // Reset after byte 2 of a 5-byte packet.
    wn = 0; tn = 0;
    load(1, 8'h80, 5); drive();
    run_until(2, 20);
    chk("mr_two", wn, 2);
    rst_n = 1'b0; #1;
    chk("mr_wr_forced", wr_uart, 0);
    chk("mr_ready_forced", req_ready, 0);
    tick();
    chk("mr_grant", grant, 0);
    load(0, 8'h90, 1); load(2, 8'h91, 1); drive();
    tick();
    chk("mr_no_wr", wn, 2);
    rst_n = 1'b1;
    tick();
    chk("mr_fresh_grant", grant, 3'b001);
    run_until(7, 40);
    chk("mr_count", wn, 7);
    chk("mr_d2", wlog[2], 8'h90);
    chk("mr_d3", wlog[3], 8'h82);
    chk("mr_d6", wlog[6], 8'h91);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Packet-granular round-robin arbiter that shares the single transmit path of the `uart` block (`wr_uart` / `wr_data` / `tx_full`) between `N_REQ` byte-stream requesters, such as the SD-card status logger and the command echo. A requester that wins arbitration is locked onto the UART until it marks its last byte, so packets are never interleaved. A per-packet length limit forces release so that one requester cannot starve the others.

## Interface
- `N_REQ`, default 3: number of requesters, 2..8.
- `DBIT`, default 8: data bits per byte; must match the `uart` `DBIT`.
- `MAX_PKT`, default 64: maximum bytes per grant before forced release, 1..255.

- `clk`  in  1: system clock; the single clock domain.
- `rst_n`  in  1: synchronous, active-low reset, sampled on the rising edge of `clk`.
- `req_valid`  in  N_REQ: requester i has a byte on `req_data[i*DBIT +: DBIT]`.
- `req_data`  in  N_REQ*DBIT: packed byte lanes.
- `req_last`  in  N_REQ: the presented byte is the final byte of its packet.
- `req_ready`  out  N_REQ: byte accepted this cycle from requester i; at most one bit set.
- `grant`  out  N_REQ: one-hot owner of the UART; all zero when idle.
- `trunc`  out  1: one-cycle pulse when a grant is force-released at `MAX_PKT`.
- `wr_uart`  out  1: write strobe to the `uart` TX FIFO.
- `wr_data`  out  DBIT: byte to the `uart` TX FIFO.
- `tx_full`  in  1: `uart` TX FIFO full.

## Operation
- **States:**
  - IDLE: `grant` is 0.
  - LOCK: `grant` is one-hot.
- **IDLE:**
  - If any `req_valid` is high, select the first set bit scanning upward (with wrap) from `ptr+1`.
  - Register the selection into `grant`, set `ptr` to the winner, clear `cnt`, and go to LOCK.
  - If no `req_valid` is high, stay in IDLE.
  - `req_valid` is only inspected for arbitration in IDLE.
- **LOCK, transfer condition:**
  - `fire = req_valid[g] & ~tx_full & rst_n`, where g is the granted index.
  - `req_ready[g] = fire`.
  - `wr_uart = fire`.
  - `wr_data = req_data` lane g, combinational.
  - Every other `req_ready` bit is 0.
- **On fire:**
  - `cnt` increments.
  - If `req_last[g]` is high, go to IDLE.
  - Otherwise, if `cnt+1 == MAX_PKT`, go to IDLE and pulse `trunc` on the next cycle.
  - The requester's remaining bytes then re-arbitrate as a new packet.
- **Non-granted requesters:** ignored while locked. Their `valid`, `data` and `last` must be held stable until `ready`.
- **Granted requester drops `req_valid` mid-packet:** the grant is held. No timeout; requesters must not abandon packets.
- **`tx_full` high:** no fire. The grant and the byte are held, with no data loss.
- **Width rules:**
  - `cnt` is 8 bits and never exceeds `MAX_PKT`.
  - `ptr` is clog2(N_REQ) bits and wraps from N_REQ-1 to 0.
- **Reset:**
  - `state` = IDLE, `grant` = 0, `cnt` = 0, `trunc` = 0.
  - `ptr` = N_REQ-1, so requester 0 has priority after reset.
  - `wr_uart` and `req_ready` are forced 0 combinationally while `rst_n` is low.
  - Reset mid-packet abandons the packet; the partial bytes already written remain in the UART FIFO.

## Timing
- **Arbitration latency:** `req_valid` rising in IDLE at edge k gives `grant` valid after edge k+1. The first fire can occur in cycle k+1.
- **Throughput:** one byte per clock while `tx_full` is low. The UART FIFO `full` updates one cycle after a write, so `tx_full` is sampled fresh each cycle with no overrun.
- **Inter-packet bubble:** exactly one IDLE cycle after the last or forced-release fire, before the next grant.
- **Back-to-back owners:** the round-robin order is strict. A requester re-asserting immediately after its own packet is served after all other pending requesters.
- **Simultaneous events:**
  - `req_last` and `MAX_PKT` on the same fire: the release is normal and `trunc` stays 0.
  - `tx_full` rising in the same cycle as `req_valid`: no fire.
- **`trunc` timing:** `trunc` is high for exactly the cycle after the releasing fire, aligned with IDLE.

## Test plan
- **Reset defaults:** hold `rst_n` = 0 for 3 cycles with all `req_valid` high. Require `grant` = 0, `wr_uart` = 0, `req_ready` = 0 throughout. After release, the first grant is 3'b001.
- **Round-robin:**
  - Stimulus: all three requesters each send a 2-byte packet (0xA0/0xA1, 0xB0/0xB1, 0xC0/0xC1), continuously valid.
  - Required `wr_data` sequence: A0 A1 B0 B1 C0 C1. There is a single `wr_uart`-low cycle between packets, and `grant` follows 001 → 010 → 100.
- **Backpressure:**
  - Stimulus: requester 1 sends a 4-byte packet while `tx_full` is high for cycles 2-5.
  - Required response: no `wr_uart` while full. The bytes arrive in order 0x10..0x13 with none lost or duplicated, and the grant is held across the stall.
- **Forced release:**
  - Stimulus: `MAX_PKT` = 4, requester 0 streams 6 bytes with `req_last` on the 6th, and requester 2 is pending.
  - Required response: 4 bytes, then `trunc` high for 1 cycle, then requester 2's packet, then requester 0's remaining 2 bytes.
- **Last at limit:**
  - Stimulus: `MAX_PKT` = 4 with a 4-byte packet whose last byte carries `req_last`.
  - Required response: `trunc` stays 0.
- **Mid-packet reset:** assert `rst_n` = 0 after byte 2 of a 5-byte packet. Require `grant` = 0 after the edge, no further `wr_uart`, and fresh arbitration from requester 0.
